prog_rom: RTL and testbench
===========================

# prog_rom

Parametrised, loadable instruction memory that replaces the fixed case-table ROM feeding the fetch stage. A load port writes program words at run time. A read-request handshake returns a word after a configurable number of wait states, and the result is driven onto a shared tri-state data bus gated by chip select and output enable. Misaligned and out-of-range reads are flagged rather than silently returning zero.

## Interface
- `ADDR_W`, 32: byte-address width.
- `WORD_W`, 32: stored word width, in bits. Must be a multiple of 8 and a power of two.
- `DATA_W`, 64: bus width. `WORD_W` ≤ `DATA_W`; the stored word is zero-extended onto the bus.
- `DEPTH`, 256: number of stored words.
- `WAIT_STATES`, 0: extra cycles between request and data. Range 0–15.
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in `ADDR_W`: read byte address, sampled with `read_req`.
- `read_req` in 1: one-cycle read request.
- `chip_select` in 1: enables acceptance of requests and bus drive.
- `output_enable` in 1: bus drive enable.
- `data` out (tri-state) `DATA_W`: read data bus.
- `data_valid` out 1: one-cycle pulse when a read completes.
- `addr_fault` out 1: pulses together with `data_valid` for a bad address.
- `busy` out 1: high while a read is outstanding.
- `load_en` in 1: write strobe for the load port.
- `load_addr` in `ADDR_W`: load byte address.
- `load_data` in `WORD_W`: load word.

## Operation
- Word index is `address >> log2(WORD_W/8)`. An address is misaligned if any of its low `log2(WORD_W/8)` bits is nonzero. It is out of range if the index ≥ `DEPTH`.
- FSM has three states: IDLE, WAIT, VALID.
  - IDLE → WAIT when `read_req` & `chip_select`. The address is latched and the wait counter loads `WAIT_STATES`.
  - If `WAIT_STATES` = 0, IDLE goes directly to VALID.
  - WAIT decrements the counter each cycle and goes to VALID when the counter reaches 0.
  - VALID → IDLE unconditionally, after one cycle.
- On entry to VALID:
  - Output register ← zero-extended `mem[index]`.
  - If the latched address was misaligned or out of range, the output register ← 0 and `addr_fault` = 1.
  - `data_valid` = 1 during the VALID cycle only.
- `busy` = 1 in WAIT and VALID. `read_req` while busy is ignored, not queued.
- If `chip_select` falls during WAIT: abort to IDLE, no `data_valid`, output register unchanged.
- Load port:
  - `load_en` is accepted in any state; it writes `mem[load index]` at the clock edge.
  - Misaligned or out-of-range loads are dropped silently.
  - A load to the same index in the cycle a read enters VALID: the read returns the old word (read-before-write). A load in any earlier cycle of an outstanding read is visible to that read.
- Bus: `data` = output register when `chip_select` & `output_enable`, else high-Z. Drive is independent of FSM state; the last read result is held on the bus.
- Memory contents are not cleared by reset and are undefined until loaded.

## Timing
- Read latency: `data_valid` is asserted `WAIT_STATES`+1 cycles after the `read_req` edge.
- Maximum throughput: one read per `WAIT_STATES`+2 cycles, since the next request is only accepted in IDLE.
- Reset values: FSM = IDLE, counter = 0, output register = 0, `data_valid` = 0, `addr_fault` = 0, `busy` = 0.
- `data` is therefore 0 when enabled after reset.
- Reset mid-read: the next cycle is IDLE with no `data_valid`. A load in the reset cycle is still performed.
- Bus enable/disable is combinational, with zero-cycle response to `chip_select` and `output_enable`.

## Structure
- Shared CPU package holds:
  - FSM state encoding: IDLE = 2'd0, WAIT = 2'd1, VALID = 2'd2.
  - The `index_of` / `is_aligned` address helpers, which are shared with the data memory.
- Reuse the existing `triState` cell for the bus driver. No other sub-module.
- Memory is a plain register array, with one synchronous write port and one registered read.

## Test plan
- Reset, then raise `chip_select` & `output_enable` with no read → `data` = 0, `busy` = 0, `data_valid` = 0.
- `WAIT_STATES`=0: load 0x9100_2BE0 at 0x0, request 0x0 → `data_valid` 1 cycle later, `data` = 0x0000_0000_9100_2BE0, `addr_fault` = 0.
- `WAIT_STATES`=3:
  - Load 0xF800_0000 at 0x18, request 0x18 → `busy` for 4 cycles, `data_valid` 4 cycles after the request.
  - A second `read_req` during WAIT is ignored.
- Request 0x2 (misaligned), then request 4×`DEPTH` (out of range) → each completes with `data_valid` = `addr_fault` = 1 and `data` = 0.
- `WAIT_STATES`=2:
  - Drop `chip_select` one cycle after the request → no `data_valid`, and the previous bus value is retained.
  - Load to the in-flight index in the VALID-entry cycle → the old word is returned.
- Assert `reset` during WAIT → next cycle `busy` = 0, `data_valid` = 0. With `output_enable` low, `data` = Z.

Source files
------------

// File: rtl/prog_rom_pkg.sv
// Shared CPU package: fetch-side FSM encoding and the word-address helpers
// used by both the instruction ROM and the data memory.
package prog_rom_pkg;

    // Wait-state counter width; covers the 0..15 wait-state range.
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MAX_WAITS = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } rom_state_e;

    // Word index of a byte address; lsb = log2(bytes per word).
    function automatic logic [63:0] index_of(input logic [63:0] addr,
                                             input int unsigned lsb);
        return addr >> lsb;
    endfunction

    // True when none of the low lsb address bits are set.
    function automatic logic is_aligned(input logic [63:0] addr,
                                        input int unsigned lsb);
        logic [63:0] mask;
        mask = (64'd1 << lsb) - 64'd1;
        return (addr & mask) == '0;
    endfunction

endpackage

// File: rtl/prog_rom_tristate.sv
// Tri-state bus driver cell: drives data_i when en_i, otherwise high-Z.
module triState #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] data_i,
    input  logic         en_i,
    output tri   [W-1:0] data_o
);

    assign data_o = en_i ? data_i : 'z;

endmodule

// File: rtl/prog_rom.sv
// Loadable instruction memory with a wait-stated read handshake, fault
// flagging for misaligned/out-of-range reads, and a tri-state read bus.
module prog_rom
    import prog_rom_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read_req,
    input  logic              chip_select,
    input  logic              output_enable,
    output tri   [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              addr_fault,
    output logic              busy,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data
);

    localparam int unsigned LSB   = $clog2(WORD_W / 8);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem_q [DEPTH];

    rom_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] out_q,   out_d;
    logic              fault_q, fault_d;

    logic [ADDR_W-1:0] rd_addr;
    logic [63:0]       rd_idx;
    logic [63:0]       ld_idx;
    logic              rd_ok;
    logic              ld_ok;
    logic              enter_valid;

    // Address decode for the read and load ports. With zero wait states the
    // read enters VALID straight from IDLE, before the latched copy exists,
    // so the live address is used while idle.
    always_comb begin
        rd_addr = (state_q == IDLE) ? address : addr_q;
        rd_idx  = index_of(64'(rd_addr), LSB);
        rd_ok   = is_aligned(64'(rd_addr), LSB) && (rd_idx < 64'(DEPTH));
        ld_idx  = index_of(64'(load_addr), LSB);
        ld_ok   = is_aligned(64'(load_addr), LSB) && (ld_idx < 64'(DEPTH));
    end

    // Read FSM next-state, wait counter and address latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        enter_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_req && chip_select) begin
                    addr_d = address;
                    cnt_d  = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d     = VALID;
                        enter_valid = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!chip_select) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d     = VALID;
                        enter_valid = 1'b1;
                    end
                end
            end
            VALID: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register capture on VALID entry; a bad address yields zero and
    // raises the fault flag instead of returning a stored word.
    always_comb begin
        out_d   = out_q;
        fault_d = fault_q;
        if (enter_valid) begin
            if (rd_ok) begin
                out_d   = DATA_W'(mem_q[rd_idx[IDX_W-1:0]]);
                fault_d = 1'b0;
            end else begin
                out_d   = '0;
                fault_d = 1'b1;
            end
        end
    end

    // Control and output state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            out_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            fault_q <= fault_d;
        end
    end

    // Load port write; independent of reset so a load in the reset cycle
    // still lands, and the non-blocking write gives read-before-write when
    // it coincides with the VALID-entry capture.
    always_ff @(posedge clock) begin
        if (load_en && ld_ok) begin
            mem_q[ld_idx[IDX_W-1:0]] <= load_data;
        end
    end

    assign data_valid = (state_q == VALID);
    assign busy       = (state_q != IDLE);
    assign addr_fault = data_valid && fault_q;

    triState #(.W(DATA_W)) u_bus_drv (
        .data_i (out_q),
        .en_i   (chip_select && output_enable),
        .data_o (data)
    );

endmodule

// File: tb/tb_prog_rom.sv
// Scoreboard bench for prog_rom: three instances (0, 3 and 2 wait states)
// share the load port; each has its own chip select and response queue.
module tb_prog_rom;

    typedef struct {
        logic [63:0] d;
        logic        f;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        rreq;
    logic        oe;
    logic        cs0, cs1, cs2;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        zdrv;

    wire  [63:0] bus0, bus1, bus2;
    logic        dv0, dv1, dv2;
    logic        flt0, flt1, flt2;
    logic        bsy0, bsy1, bsy2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_err    = 0;

    // Bench-side zero driver: only enabled when the DUT must be high-Z, so
    // any DUT drive shows up as a nonzero or unknown value.
    assign bus0 = zdrv ? 64'd0 : 'z;
    assign bus1 = zdrv ? 64'd0 : 'z;
    assign bus2 = zdrv ? 64'd0 : 'z;

    prog_rom #(.ADDR_W(32), .WORD_W(32), .DATA_W(64), .DEPTH(256), .WAIT_STATES(0)) u0 (
        .clock(clk), .reset(rst), .address(addr), .read_req(rreq),
        .chip_select(cs0), .output_enable(oe), .data(bus0),
        .data_valid(dv0), .addr_fault(flt0), .busy(bsy0),
        .load_en(ld_en), .load_addr(ld_addr), .load_data(ld_data)
    );

    prog_rom #(.ADDR_W(32), .WORD_W(32), .DATA_W(64), .DEPTH(256), .WAIT_STATES(3)) u1 (
        .clock(clk), .reset(rst), .address(addr), .read_req(rreq),
        .chip_select(cs1), .output_enable(oe), .data(bus1),
        .data_valid(dv1), .addr_fault(flt1), .busy(bsy1),
        .load_en(ld_en), .load_addr(ld_addr), .load_data(ld_data)
    );

    prog_rom #(.ADDR_W(32), .WORD_W(32), .DATA_W(64), .DEPTH(256), .WAIT_STATES(2)) u2 (
        .clock(clk), .reset(rst), .address(addr), .read_req(rreq),
        .chip_select(cs2), .output_enable(oe), .data(bus2),
        .data_valid(dv2), .addr_fault(flt2), .busy(bsy2),
        .load_en(ld_en), .load_addr(ld_addr), .load_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic logic dv_of(input int ch);
        case (ch)
            0:       return dv0;
            1:       return dv1;
            default: return dv2;
        endcase
    endfunction

    function automatic void sb_push(input int ch, input logic [63:0] d, input logic f);
        exp_t e;
        e.d = d;
        e.f = f;
        case (ch)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic void sb_pop(input int ch, input logic [63:0] d, input logic f);
        exp_t e;
        logic have;
        have = 1'b0;
        case (ch)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_checks++;
            n_err++;
            $display("FAIL sb_unexpected_ch%0d: got data_valid with data 0x%0h, expected no response", ch, d);
        end else begin
            check($sformatf("sb_data_ch%0d", ch), d, e.d);
            check($sformatf("sb_fault_ch%0d", ch), 64'(f), 64'(e.f));
        end
    endfunction

    // Monitor: pops one expected response per data_valid pulse.
    always @(negedge clk) begin
        if (dv0) sb_pop(0, bus0, flt0);
        if (dv1) sb_pop(1, bus1, flt1);
        if (dv2) sb_pop(2, bus2, flt2);
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        next();
        ld_en   = 1'b0;
    endtask

    task automatic issue(input int ch, input logic [31:0] a, input bit push,
                         input logic [63:0] ed, input logic ef);
        cs0  = (ch == 0);
        cs1  = (ch == 1);
        cs2  = (ch == 2);
        addr = a;
        rreq = 1'b1;
        if (push) sb_push(ch, ed, ef);
        next();
        rreq = 1'b0;
    endtask

    // Latency counted in cycles from the request edge; bounded wait.
    task automatic wait_done(input int ch, input int exp_lat, input string nm);
        int lat = 1;
        while (!dv_of(ch) && lat < 32) begin
            next();
            lat++;
        end
        check(nm, 64'(lat), 64'(exp_lat));
        next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; addr = '0; rreq = 1'b0; oe = 1'b0;
        cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; zdrv = 1'b0;
        repeat (2) next();
        rst = 1'b0;

        // Reset state visible on an enabled bus
        cs0 = 1'b1; cs1 = 1'b1; cs2 = 1'b1; oe = 1'b1;
        #1;
        check("rst_bus0", bus0, 64'd0);
        check("rst_bus1", bus1, 64'd0);
        check("rst_bus2", bus2, 64'd0);
        check("rst_busy0", 64'(bsy0), 64'd0);
        check("rst_busy1", 64'(bsy1), 64'd0);
        check("rst_dv0", 64'(dv0), 64'd0);
        check("rst_fault0", 64'(flt0), 64'd0);

        // Program image; 0x1A is misaligned and 0x400 out of range (dropped)
        load(32'h0000_0000, 32'h9100_2BE0);
        load(32'h0000_0018, 32'hF800_0000);
        load(32'h0000_03FC, 32'h1234_5678);
        load(32'h0000_001A, 32'hDEAD_BEEF);
        load(32'h0000_0400, 32'hCAFE_F00D);
        load(32'h0000_0020, 32'h1111_1111);

        // Zero wait states
        issue(0, 32'h0, 1'b1, 64'h0000_0000_9100_2BE0, 1'b0);
        check("ws0_dv", 64'(dv0), 64'd1);
        check("ws0_fault", 64'(flt0), 64'd0);
        check("ws0_bus", bus0, 64'h0000_0000_9100_2BE0);
        next();
        check("ws0_dv_clear", 64'(dv0), 64'd0);
        check("ws0_busy_clear", 64'(bsy0), 64'd0);
        issue(0, 32'h3FC, 1'b1, 64'h0000_0000_1234_5678, 1'b0);
        wait_done(0, 1, "ws0_lat_last_word");

        // Three wait states, with an ignored second request during WAIT
        issue(1, 32'h18, 1'b1, 64'h0000_0000_F800_0000, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("ws3_busy_c%0d", c), 64'(bsy1), 64'(c <= 4));
            check($sformatf("ws3_dv_c%0d", c), 64'(dv1), 64'(c == 4));
            rreq = (c == 2);
            addr = 32'h0;
            next();
        end
        rreq = 1'b0;

        // Bad addresses
        issue(1, 32'h2, 1'b1, 64'd0, 1'b1);
        wait_done(1, 4, "ws3_misaligned_lat");
        issue(1, 32'd1024, 1'b1, 64'd0, 1'b1);
        wait_done(1, 4, "ws3_out_of_range_lat");

        // Two wait states: normal read, then chip-select abort
        issue(2, 32'h18, 1'b1, 64'h0000_0000_F800_0000, 1'b0);
        wait_done(2, 3, "ws2_lat");
        issue(2, 32'h0, 1'b0, 64'd0, 1'b0);
        cs2 = 1'b0;
        next();
        check("ws2_abort_busy", 64'(bsy2), 64'd0);
        check("ws2_abort_dv", 64'(dv2), 64'd0);
        zdrv = 1'b1;
        #1;
        check("ws2_cs_low_busZ", bus2, 64'd0);
        zdrv = 1'b0;
        next();
        check("ws2_abort_dv_later", 64'(dv2), 64'd0);
        cs2 = 1'b1;
        #1;
        check("ws2_bus_retained", bus2, 64'h0000_0000_F800_0000);

        // Load in the VALID-entry cycle: old word returned
        issue(2, 32'h20, 1'b1, 64'h0000_0000_1111_1111, 1'b0);
        next();
        ld_en = 1'b1; ld_addr = 32'h20; ld_data = 32'h2222_2222;
        next();
        ld_en = 1'b0;
        check("ws2_rbw_dv", 64'(dv2), 64'd1);
        next();
        check("ws2_rbw_idle", 64'(bsy2), 64'd0);

        // Load during WAIT: visible to the outstanding read
        issue(2, 32'h20, 1'b1, 64'h0000_0000_3333_3333, 1'b0);
        load(32'h20, 32'h3333_3333);
        wait_done(2, 2, "ws2_lat_after_wait_load");

        // Reset during WAIT, with a load in the reset cycle
        issue(1, 32'h18, 1'b0, 64'd0, 1'b0);
        rst = 1'b1;
        ld_en = 1'b1; ld_addr = 32'h28; ld_data = 32'h5555_5555;
        next();
        check("rstw_busy", 64'(bsy1), 64'd0);
        check("rstw_dv", 64'(dv1), 64'd0);
        rst = 1'b0;
        ld_en = 1'b0;
        oe = 1'b0;
        zdrv = 1'b1;
        #1;
        check("rstw_oe_low_busZ", bus1, 64'd0);
        zdrv = 1'b0;
        oe = 1'b1;
        #1;
        check("rstw_bus_cleared", bus1, 64'd0);
        next();
        check("rstw_dv_later", 64'(dv1), 64'd0);
        issue(1, 32'h28, 1'b1, 64'h0000_0000_5555_5555, 1'b0);
        wait_done(1, 4, "rstw_reset_cycle_load");

        repeat (3) next();
        check("sb_drain", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
